pe_wsdb: RTL

Next-generation weight-stationary systolic processing element.
- Signed, parametrised operand and accumulator widths.
- NUM_BANKS stationary-weight banks, so the next weight can be loaded while the current one computes.
- Valid flags travel with the data; optional product pipeline stage; optional saturating accumulate.
- Tiled into the 2-D systolic array: activations move left→right, partial sums move top→bottom.

---
 rtl/pe_wsdb_pkg.sv | 28 ++
 rtl/pe_wsdb_mac_sat.sv | 63 ++++++
 rtl/pe_wsdb.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pe_wsdb_pkg.sv
// Shared types and helpers for the weight-stationary PE.
package pe_wsdb_pkg;

    typedef enum logic [1:0] {
        PE_IDLE = 2'd0,
        PE_PASS = 2'd1,
        PE_LOAD = 2'd2,
        PE_PROC = 2'd3
    } pe_mode_t;

    // Clamp a signed value to the signed range of 'width' bits (width < 64).
    // The caller truncates the result to 'width' bits.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                     input int unsigned         width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/pe_wsdb_mac_sat.sv
// Signed multiply, optional product register, widened add and saturate/wrap.
module pe_mac_sat
    import pe_wsdb_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned PIPE     = 0,
    parameter int unsigned SATURATE = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [DATA_W-1:0] weight_i,
    input  logic signed [DATA_W-1:0] act_i,
    input  logic signed [ACC_W-1:0]  addend_i,
    input  logic                     valid_i,
    output logic signed [ACC_W-1:0]  sum_c,
    output logic                     valid_c
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  addend_s;
    logic                     valid_s;
    logic signed [ACC_W:0]    sum_wide;

    assign prod = PROD_W'(weight_i) * PROD_W'(act_i);

    if (PIPE != 0) begin : g_pipe
        // Stage 1: register product, addend and qualifying valid.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                prod_s   <= '0;
                addend_s <= '0;
                valid_s  <= 1'b0;
            end else begin
                prod_s   <= prod;
                addend_s <= addend_i;
                valid_s  <= valid_i;
            end
        end
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign prod_s   = prod;
        assign addend_s = addend_i;
        assign valid_s  = valid_i;
    end

    // One guard bit above the accumulator so overflow is visible.
    assign sum_wide = {{(ACC_W + 1 - PROD_W){prod_s[PROD_W-1]}}, prod_s}
                    + {addend_s[ACC_W-1], addend_s};

    if (SATURATE != 0) begin : g_sat
        assign sum_c = ACC_W'(sat_trunc({{(63 - ACC_W){sum_wide[ACC_W]}}, sum_wide}, ACC_W));
    end else begin : g_wrap
        assign sum_c = sum_wide[ACC_W-1:0];
    end

    assign valid_c = valid_s;

endmodule

// File: rtl/pe_wsdb.sv
// Weight-stationary systolic PE with multiple weight banks.
module pe_wsdb
    import pe_wsdb_pkg::*;
#(
    parameter  int unsigned DATA_W    = 8,
    parameter  int unsigned ACC_W     = 24,
    parameter  int unsigned NUM_BANKS = 2,
    parameter  int unsigned PIPE      = 0,
    parameter  int unsigned SATURATE  = 1,
    localparam int unsigned BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic signed [ACC_W-1:0]  top_i,
    input  logic                     top_valid_i,
    input  logic signed [DATA_W-1:0] left_i,
    input  logic                     left_valid_i,
    output logic signed [DATA_W-1:0] right_o,
    output logic                     right_valid_o,
    output logic signed [ACC_W-1:0]  bottom_o,
    output logic                     bottom_valid_o,
    input  pe_mode_t                 mode_i,
    input  logic [BANK_W-1:0]        load_bank_i,
    input  logic                     swap_i,
    input  logic                     add_zero_i,
    output logic [BANK_W-1:0]        active_bank_o,
    output logic                     err_o
);

    if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
        $error("pe_wsdb: ACC_W must be at least 2*DATA_W");
    end
    if (ACC_W > 63) begin : g_bad_acc_max
        $error("pe_wsdb: ACC_W must be at most 63");
    end
    if (NUM_BANKS < 1) begin : g_bad_banks
        $error("pe_wsdb: NUM_BANKS must be at least 1");
    end

    logic signed [DATA_W-1:0] bank_q [NUM_BANKS];
    logic signed [DATA_W-1:0] weight_c;
    logic                     load_req;
    logic                     bank_oob;
    logic                     hit_active;
    logic                     load_ok;
    logic [BANK_W-1:0]        next_bank;
    logic signed [ACC_W-1:0]  mac_addend;
    logic                     mac_valid_in;
    logic signed [ACC_W-1:0]  mac_sum_c;
    logic                     mac_valid_c;

    // Loads are checked against the pointer before any same-cycle swap.
    assign load_req   = (mode_i == PE_LOAD) && top_valid_i;
    assign bank_oob   = 32'(load_bank_i) >= NUM_BANKS;
    assign hit_active = (NUM_BANKS > 1) && (load_bank_i == active_bank_o);
    assign load_ok    = load_req && !bank_oob && !hit_active;
    assign next_bank  = (32'(active_bank_o) == NUM_BANKS - 1) ? '0 : active_bank_o + BANK_W'(1);

    if (NUM_BANKS == 1) begin : g_one_bank
        assign weight_c = bank_q[0];
    end else begin : g_multi_bank
        assign weight_c = bank_q[active_bank_o];
    end

    assign mac_addend   = add_zero_i ? '0 : top_i;
    assign mac_valid_in = (mode_i == PE_PROC) && left_valid_i && (add_zero_i || top_valid_i);

    // Stationary weight bank file.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                bank_q[b] <= '0;
            end
        end else if (load_ok) begin
            for (int b = 0; b < int'(NUM_BANKS); b++) begin
                if (load_bank_i == BANK_W'(b)) begin
                    bank_q[b] <= top_i[DATA_W-1:0];
                end
            end
        end
    end

    // Active bank pointer and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_bank_o <= '0;
            err_o         <= 1'b0;
        end else begin
            if (swap_i) begin
                active_bank_o <= next_bank;
            end
            if (load_req && !load_ok) begin
                err_o <= 1'b1;
            end
        end
    end

    pe_mac_sat #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .PIPE    (PIPE),
        .SATURATE(SATURATE)
    ) u_mac (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .weight_i(weight_c),
        .act_i   (left_i),
        .addend_i(mac_addend),
        .valid_i (mac_valid_in),
        .sum_c   (mac_sum_c),
        .valid_c (mac_valid_c)
    );

    // Activation forwarding and partial-sum output; an in-flight MAC result wins over the current mode.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            right_o        <= '0;
            right_valid_o  <= 1'b0;
            bottom_o       <= '0;
            bottom_valid_o <= 1'b0;
        end else begin
            right_o       <= left_i;
            right_valid_o <= left_valid_i;
            if (mac_valid_c) begin
                bottom_o       <= mac_sum_c;
                bottom_valid_o <= 1'b1;
            end else if (mode_i == PE_PASS) begin
                bottom_o       <= top_i;
                bottom_valid_o <= top_valid_i;
            end else begin
                bottom_valid_o <= 1'b0;
            end
        end
    end

endmodule
